// File: rtl/rr_chan_mux_pkg.sv
// rr_chan_mux shared definitions:
// mode encoding and index-width helper.
package rr_chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2)
      r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter:
// lowest wrapped distance from ptr wins.
module rr_arbiter
  import rr_chan_mux_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int SELW = clog2(NCH)
) (
  input  logic [SELW-1:0] ptr,
  input  logic [NCH-1:0]  req,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] idx,
  output logic            any
);

  int d;
  int best;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    d    = 0;
    best = NCH;
    for (int i = 0; i < NCH; i++) begin
      // distance wraps at NCH, not 2^SELW
      d = i - int'(ptr);
      if (d < 0)
        d = d + NCH;
      if (req[i] && d < best) begin
        best   = d;
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = SELW'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_chan_mux.sv
// N-channel registered selector with fixed
// and round-robin modes, valid/ready on all sides.
module rr_chan_mux
  import rr_chan_mux_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NCH   = 4,
  localparam int SELW  = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  localparam logic S_EMPTY = 1'b0;
  localparam logic S_FULL  = 1'b1;

  logic             state;
  logic [SELW-1:0]  ptr;
  logic [NCH-1:0]   rr_gnt;
  logic [NCH-1:0]   fx_gnt;
  logic [NCH-1:0]   gnt;
  logic [SELW-1:0]  rr_idx;
  logic [SELW-1:0]  gidx;
  logic             rr_any;
  logic             any;
  logic             load_en;
  logic [WIDTH-1:0] gdata;

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .ptr (ptr),
    .req (in_valid),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  // out-of-range sel matches no channel
  always_comb begin
    fx_gnt = '0;
    for (int i = 0; i < NCH; i++)
      fx_gnt[i] = in_valid[i] && (sel == SELW'(i));
  end

  assign gnt  = (mode == MODE_RR) ? rr_gnt : fx_gnt;
  assign gidx = (mode == MODE_RR) ? rr_idx : sel;
  assign any  = (mode == MODE_RR) ? rr_any : |fx_gnt;

  always_comb begin
    gdata = '0;
    for (int i = 0; i < NCH; i++)
      if (gnt[i])
        gdata = in_data[i*WIDTH +: WIDTH];
  end

  assign out_valid = (state == S_FULL);
  assign load_en   = !out_valid || out_ready;
  assign in_ready  = (rst_n && load_en) ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_EMPTY;
      out_data <= '0;
      out_ch   <= '0;
      ptr      <= '0;
    end else if (load_en) begin
      state <= any ? S_FULL : S_EMPTY;
      if (any) begin
        out_data <= gdata;
        out_ch   <= gidx;
        if (mode == MODE_RR)
          ptr <= (gidx == SELW'(NCH-1)) ? '0 : gidx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rr_chan_mux.sv
// Bench for rr_chan_mux: NCH=4 and NCH=3
// instances against a behavioural model.
module tb_rr_chan_mux;
  import rr_chan_mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  sel = '0;
  logic [3:0]  va = '0;
  logic [15:0] da = '0;

  logic [3:0]  rdy_a;
  logic        ova;
  logic [3:0]  oda;
  logic [1:0]  oca;
  logic [2:0]  rdy_b;
  logic        ovb;
  logic [3:0]  odb;
  logic [1:0]  ocb;

  int errors = 0;
  int checks = 0;
  int mv[2], md[2], mc[2], mp[2];

  always #5 clk = ~clk;

  rr_chan_mux #(.WIDTH(4), .NCH(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (va),
    .in_data   (da),
    .in_ready  (rdy_a),
    .out_valid (ova),
    .out_data  (oda),
    .out_ch    (oca),
    .out_ready (out_ready)
  );

  rr_chan_mux #(.WIDTH(4), .NCH(3)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (va[2:0]),
    .in_data   (da[11:0]),
    .in_ready  (rdy_b),
    .out_valid (ovb),
    .out_data  (odb),
    .out_ch    (ocb),
    .out_ready (out_ready)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // channel the rules say must win, or -1
  function automatic int pick(input int n, input logic m,
                              input logic [1:0] s,
                              input logic [3:0] v, input int p);
    if (m == MODE_FIXED)
      return (int'(s) < n && v[s]) ? int'(s) : -1;
    for (int k = 0; k < n; k++)
      if (v[(p + k) % n])
        return (p + k) % n;
    return -1;
  endfunction

  task automatic cyc();
    int g[2];
    int le[2];
    int n;
    logic [3:0] v;
    string t;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 3;
      t = (k == 0) ? "A" : "B";
      v = (k == 0) ? va : {1'b0, va[2:0]};
      if (!rst_n) begin
        mv[k] = 0; md[k] = 0; mc[k] = 0; mp[k] = 0;
      end
      le[k] = (mv[k] == 0 || out_ready) ? 1 : 0;
      g[k] = pick(n, mode, sel, v, mp[k]);
      chk({t, ".in_ready"},
          (k == 0) ? int'(rdy_a) : int'(rdy_b),
          (rst_n && le[k] == 1 && g[k] >= 0) ? (1 << g[k]) : 0);
      chk({t, ".out_valid"},
          (k == 0) ? int'(ova) : int'(ovb), mv[k]);
      if (mv[k] != 0 || !rst_n) begin
        chk({t, ".out_data"},
            (k == 0) ? int'(oda) : int'(odb), md[k]);
        chk({t, ".out_ch"},
            (k == 0) ? int'(oca) : int'(ocb), mc[k]);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 3;
      if (rst_n && le[k] == 1) begin
        if (g[k] >= 0) begin
          mv[k] = 1;
          md[k] = int'(da[g[k]*4 +: 4]);
          mc[k] = g[k];
          if (mode == MODE_RR)
            mp[k] = (g[k] + 1) % n;
        end else begin
          mv[k] = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0; md[k] = 0; mc[k] = 0; mp[k] = 0;
    end
    va = 4'b1111;
    da = 16'($urandom);
    repeat (2) cyc();
    #1;
    chk("rst.in_ready", int'(rdy_a), 0);
    chk("rst.out_valid", int'(ova), 0);
    chk("rst.out_data", int'(oda), 0);
    rst_n = 1'b1;
    mode = MODE_RR;
    cyc();
    chk("first.out_valid", int'(ova), 1);
    chk("first.out_ch", int'(oca), 0);

    mode = MODE_FIXED;
    sel = 2'd2;
    da = 16'($urandom);
    da[11:8] = 4'b1010;
    #1 chk("fix.in_ready", int'(rdy_a), 4);
    cyc();
    chk("fix.out_data", int'(oda), 10);
    chk("fix.out_ch", int'(oca), 2);
    sel = 2'd1;
    va = 4'b1101;
    #1 chk("hold.in_ready", int'(rdy_a), 0);
    cyc();
    chk("hold.out_valid", int'(ova), 0);

    do_reset();
    mode = MODE_RR;
    va = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      da = 16'($urandom);
      cyc();
      chk("rr4.out_ch", int'(oca), i % 4);
      chk("rr3.out_ch", int'(ocb), i % 3);
    end
    va = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("skip.out_ch", int'(oca), (i % 2 == 1) ? 3 : 1);
    end

    mode = MODE_FIXED;
    sel = 2'd0;
    va = 4'b0001;
    da[3:0] = 4'b0101;
    cyc();
    chk("bp.load", int'(oda), 5);
    out_ready = 1'b0;
    mode = MODE_RR;
    va = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      da = 16'($urandom);
      #1 chk("bp.in_ready", int'(rdy_a), 0);
      cyc();
      chk("bp.out_data", int'(oda), 5);
    end
    out_ready = 1'b1;
    #1 chk("bp.release", int'(rdy_a), 1);
    cyc();
    chk("bp.next_ch", int'(oca), 0);

    mode = MODE_FIXED;
    sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1 chk("sel3.in_ready_b", int'(rdy_b), 0);
      cyc();
    end
    chk("sel3.out_valid_b", int'(ovb), 0);

    for (int i = 0; i < 3000; i++) begin
      mode = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom);
      va = 4'($urandom);
      da = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      cyc();
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
